// File: rtl/mmss_timer_core_pkg.sv
// timer_pkg: shared states, BCD limits and preset saturation helper for the MM:SS timer
package timer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   localparam logic [3:0] BCD_MAX_ONES = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS = 4'd5;
   localparam logic [3:0] DIGIT_BLANK  = 4'hF;
   function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] mx);
      return v > mx ? mx : v;
   endfunction
endpackage

// File: rtl/mmss_timer_core_if.sv
// mmss_timer_core_if: control, preset and display signals of the MM:SS timer core
interface mmss_timer_core_if #(parameter int WIDTH = 4);
   logic             start, stop, clear, load, mode_down;
   logic [WIDTH-1:0] preset_m1, preset_m0, preset_s1, preset_s0;
   logic [WIDTH-1:0] min_tens, min_ones, sec_tens, sec_ones;
   logic             running, done;
   modport master (
      output start, stop, clear, load, mode_down, preset_m1, preset_m0, preset_s1, preset_s0,
      input  min_tens, min_ones, sec_tens, sec_ones, running, done
   );
   modport slave (
      input  start, stop, clear, load, mode_down, preset_m1, preset_m0, preset_s1, preset_s0,
      output min_tens, min_ones, sec_tens, sec_ones, running, done
   );
endinterface

// File: rtl/mmss_timer_core_bcd_digit.sv
// bcd_digit: one BCD digit 0..MAX counting up/down with ripple carry/borrow out
module bcd_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX_ONES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       down,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       co
);
   assign co = en & (down ? digit == 4'd0 : digit == MAX);
   // clear beats load beats a count step; a carrying digit wraps to its opposite limit
   always_ff @(posedge clk)
      if (rst || clr) digit <= 4'd0;
      else if (ld) digit <= ld_val;
      else if (en) digit <= co ? (down ? MAX : 4'd0) : (down ? digit - 4'd1 : digit + 4'd1);
endmodule

// File: rtl/mmss_timer_core.sv
// mmss_timer_core: MM:SS up/down timer with 1 s prescaler; define TIMER_BLINK_EN to blink digits in DONE
module mmss_timer_core
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int WIDTH         = 4
) (
   input logic              clk,
   input logic              rst,
   mmss_timer_core_if.slave bus
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   state_t           state, state_nx;
   logic             done_r, done_nx, tick, zero, hit, uf, clr, blank;
   logic [PW-1:0]    pre;
   logic [WIDTH-1:0] mt, mo, st, so;
   logic [4:0]       c;
   assign tick = state == RUN && pre == PMAX;
   assign zero = {mt, mo, st, so} == '0;
   assign hit  = tick & bus.mode_down & ({mt, mo, st} == '0) & (so <= WIDTH'(1));
   assign c[0] = tick;
   // a borrow out of the top digit means a down step at 00:00; hold at zero instead of wrapping
   assign uf   = c[4] & bus.mode_down;
   assign clr  = bus.clear | (uf & ~bus.load);
   bcd_digit #(.MAX(BCD_MAX_ONES)) u_so (.clk(clk), .rst(rst), .en(c[0]), .down(bus.mode_down), .ld(bus.load),
      .ld_val(sat(bus.preset_s0, BCD_MAX_ONES)), .clr(clr), .digit(so), .co(c[1]));
   bcd_digit #(.MAX(BCD_MAX_TENS)) u_st (.clk(clk), .rst(rst), .en(c[1]), .down(bus.mode_down), .ld(bus.load),
      .ld_val(sat(bus.preset_s1, BCD_MAX_TENS)), .clr(clr), .digit(st), .co(c[2]));
   bcd_digit #(.MAX(BCD_MAX_ONES)) u_mo (.clk(clk), .rst(rst), .en(c[2]), .down(bus.mode_down), .ld(bus.load),
      .ld_val(sat(bus.preset_m0, BCD_MAX_ONES)), .clr(clr), .digit(mo), .co(c[3]));
   bcd_digit #(.MAX(BCD_MAX_TENS)) u_mt (.clk(clk), .rst(rst), .en(c[3]), .down(bus.mode_down), .ld(bus.load),
      .ld_val(sat(bus.preset_m1, BCD_MAX_TENS)), .clr(clr), .digit(mt), .co(c[4]));
   // next state and done pulse; clear/load override everything, countdown completion beats stop
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      if (bus.clear || bus.load) state_nx = IDLE;
      else
         case (state)
            IDLE, PAUSE: if (bus.start) begin
               state_nx = (bus.mode_down && zero) ? DONE : RUN;
               done_nx  = bus.mode_down && zero;
            end
            RUN: if (hit) begin
               state_nx = DONE;
               done_nx  = 1'b1;
            end else if (bus.stop) state_nx = PAUSE;
            DONE: if (bus.start && !(bus.mode_down && zero)) state_nx = RUN;
            default: state_nx = IDLE;
         endcase
   end
   // state and done registers
   always_ff @(posedge clk)
      if (rst) begin
         state  <= IDLE;
         done_r <= 1'b0;
      end else begin
         state  <= state_nx;
         done_r <= done_nx;
      end
   // prescaler restarts on every entry into RUN so the first tick is a full second away
   always_ff @(posedge clk)
      if (rst || bus.clear || bus.load || (state_nx == RUN && state != RUN)) pre <= '0;
      else if (state == RUN) pre <= tick ? '0 : pre + PW'(1);
`ifdef TIMER_BLINK_EN
   logic [PW-1:0] bc;
   // blink phase counter, restarted on DONE entry so the digits are shown first
   always_ff @(posedge clk)
      if (rst || (state_nx == DONE && state != DONE)) bc <= '0;
      else if (state == DONE) bc <= bc == PMAX ? '0 : bc + PW'(1);
   assign blank = state == DONE && bc >= PW'(TICKS_PER_SEC / 2);
`else
   assign blank = 1'b0;
`endif
   assign bus.min_tens = blank ? DIGIT_BLANK : mt;
   assign bus.min_ones = blank ? DIGIT_BLANK : mo;
   assign bus.sec_tens = blank ? DIGIT_BLANK : st;
   assign bus.sec_ones = blank ? DIGIT_BLANK : so;
   assign bus.running  = state == RUN;
   assign bus.done     = done_r;
endmodule

// File: tb/tb_mmss_timer_core.sv
// tb_mmss_timer_core: directed checks of the MM:SS timer core at TICKS_PER_SEC = 4
module tb_mmss_timer_core;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] dig;
`ifdef TIMER_BLINK_EN
   localparam logic [15:0] BLK = 16'hFFFF;
`else
   localparam logic [15:0] BLK = 16'h0000;
`endif
   mmss_timer_core_if bus ();
   mmss_timer_core #(.TICKS_PER_SEC(4), .WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign dig = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_load(input logic [15:0] p);
      {bus.preset_m1, bus.preset_m0, bus.preset_s1, bus.preset_s0} = p;
      bus.load = 1'b1;
      cyc(1);
      bus.load = 1'b0;
   endtask
   task automatic do_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask
   initial begin
      {bus.start, bus.stop, bus.clear, bus.load, bus.mode_down} = '0;
      {bus.preset_m1, bus.preset_m0, bus.preset_s1, bus.preset_s0} = '0;
      cyc(2);
      rst = 1'b0;
      chk("rst_dig", dig, 16'h0000);
      chk("rst_run", 16'(bus.running), 16'h0);
      chk("rst_done", 16'(bus.done), 16'h0);
      do_start();
      chk("start_run", 16'(bus.running), 16'h1);
      cyc(3);
      chk("pre_tick", dig, 16'h0000);
      cyc(1);
      chk("first_tick", dig, 16'h0001);
      do_load(16'h0058);
      chk("load_0058", dig, 16'h0058);
      chk("load_idle", 16'(bus.running), 16'h0);
      do_start();
      cyc(4);
      chk("up_0059", dig, 16'h0059);
      cyc(4);
      chk("up_0100", dig, 16'h0100);
      cyc(4);
      chk("up_0101", dig, 16'h0101);
      do_load(16'h5959);
      chk("load_5959", dig, 16'h5959);
      do_start();
      cyc(3);
      chk("pre_wrap", dig, 16'h5959);
      cyc(1);
      chk("wrap_dig", dig, 16'h0000);
      chk("wrap_nodone", 16'(bus.done), 16'h0);
      chk("wrap_run", 16'(bus.running), 16'h1);
      bus.mode_down = 1'b1;
      do_load(16'h0100);
      do_start();
      cyc(4);
      chk("dn_0059", dig, 16'h0059);
      do_load(16'h0002);
      do_start();
      cyc(4);
      chk("dn_0001", dig, 16'h0001);
      chk("dn_nodone", 16'(bus.done), 16'h0);
      cyc(4);
      chk("dn_0000", dig, 16'h0000);
      chk("dn_done", 16'(bus.done), 16'h1);
      chk("dn_norun", 16'(bus.running), 16'h0);
      cyc(1);
      chk("dn_done_fall", 16'(bus.done), 16'h0);
      chk("done_ph1", dig, 16'h0000);
      cyc(1);
      chk("done_ph2", dig, BLK);
      cyc(1);
      chk("done_ph3", dig, BLK);
      chk("done_nodone", 16'(bus.done), 16'h0);
      cyc(1);
      chk("done_ph4", dig, 16'h0000);
      bus.mode_down = 1'b0;
      do_load(16'h0010);
      do_start();
      cyc(3);
      chk("pz_pre", dig, 16'h0010);
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
      chk("pz_tick", dig, 16'h0011);
      chk("pz_norun", 16'(bus.running), 16'h0);
      cyc(10);
      chk("pz_frozen", dig, 16'h0011);
      do_start();
      chk("pz_rerun", 16'(bus.running), 16'h1);
      cyc(3);
      chk("pz_wait", dig, 16'h0011);
      cyc(1);
      chk("pz_next", dig, 16'h0012);
      do_load(16'h7A8F);
      chk("sat", dig, 16'h5959);
      bus.clear = 1'b1;
      cyc(1);
      bus.clear = 1'b0;
      chk("clr_dig", dig, 16'h0000);
      bus.mode_down = 1'b1;
      do_start();
      chk("z_done", 16'(bus.done), 16'h1);
      chk("z_norun", 16'(bus.running), 16'h0);
      cyc(1);
      chk("z_done_fall", 16'(bus.done), 16'h0);
      do_start();
      chk("z_stay", 16'(bus.running), 16'h0);
      chk("z_nodone", 16'(bus.done), 16'h0);
      bus.mode_down = 1'b0;
      do_start();
      chk("z_up_run", 16'(bus.running), 16'h1);
      bus.mode_down = 1'b1;
      do_load(16'h0001);
      do_start();
      cyc(3);
      bus.clear = 1'b1;
      bus.stop  = 1'b1;
      cyc(1);
      bus.clear = 1'b0;
      bus.stop  = 1'b0;
      chk("cs_dig", dig, 16'h0000);
      chk("cs_nodone", 16'(bus.done), 16'h0);
      chk("cs_norun", 16'(bus.running), 16'h0);
      do_start();
      chk("cs_was_idle", 16'(bus.done), 16'h1);
      bus.mode_down = 1'b0;
      do_load(16'h0030);
      do_start();
      cyc(5);
      chk("mid_cnt", dig, 16'h0031);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mid_rst_dig", dig, 16'h0000);
      chk("mid_rst_run", 16'(bus.running), 16'h0);
      chk("mid_rst_done", 16'(bus.done), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
